// File: rtl/game_pkg.sv
// Shared playfield geometry and state/direction types for the ball, brick and paddle blocks.
package game_pkg;

    localparam int FIELD_W   = 500;
    localparam int FIELD_H   = 480;
    localparam int BALL_SIZE = 20;
    localparam int PADDLE_W  = 80;
    localparam int PADDLE_Y  = 450;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_LOST,
        ST_OVER
    } state_e;

    typedef enum logic {
        DX_RIGHT,
        DX_LEFT
    } xdir_e;

    typedef enum logic {
        DY_UP,
        DY_DOWN
    } ydir_e;

endpackage

// File: rtl/step_timer.sv
// Free-running pacing counter: pulses step_o once every STEP_DELAY enabled cycles.
module step_timer #(
    parameter int STEP_DELAY = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_i,
    input  logic clear_i,
    output logic step_o
);
    localparam int CW = (STEP_DELAY > 1) ? $clog2(STEP_DELAY) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DELAY - 1);

    logic [CW-1:0] count_q;

    assign step_o = enable_i && (count_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= step_o ? '0 : count_q + 1'b1;
        end
    end

endmodule

// File: rtl/ball_ctrl.sv
// Ball position/direction controller: holds the ball on the paddle, paces its motion,
// bounces it off walls, paddle and bricks, and tracks lives through to game over.
module ball_ctrl
    import game_pkg::*;
#(
    parameter int SPEED      = 1,
    parameter int STEP_DELAY = 500000,
    parameter int LIVES      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] paddle_x,
    input  logic       launch,
    input  logic       brick_hit,
    input  logic       brick_low,
    output logic [8:0] ball_x,
    output logic [8:0] ball_y,
    output logic       ball_active,
    output logic       ball_lost,
    output logic [2:0] lives,
    output logic       game_over
);
    // All geometry is held at 10 bits so sums near the field edge cannot wrap.
    localparam logic [9:0] SPD      = 10'(SPEED);
    localparam logic [9:0] SIZE     = 10'(BALL_SIZE);
    localparam logic [9:0] X_MAX    = 10'(FIELD_W - BALL_SIZE);
    localparam logic [9:0] Y_LIMIT  = 10'(FIELD_H);
    localparam logic [9:0] PAD_Y    = 10'(PADDLE_Y);
    localparam logic [9:0] PAD_W    = 10'(PADDLE_W);
    localparam logic [9:0] REST_Y   = 10'(PADDLE_Y - BALL_SIZE);
    localparam logic [9:0] HOLD_OFS = 10'(PADDLE_W / 2 - BALL_SIZE / 2);
    localparam logic [8:0] START_X  = 9'((FIELD_W - BALL_SIZE) / 2);

    state_e     state_q, state_d;
    xdir_e      dx_q, dx_d;
    ydir_e      dy_q, dy_d;
    logic [8:0] ballX_q, ballX_d;
    logic [8:0] ballY_q, ballY_d;
    logic       hitPending_q, hitPending_d;
    logic [2:0] lives_q, lives_d;
    logic       active_q, lost_q, over_q;

    logic       step;
    logic       brickNow;
    logic       paddleHit;
    logic       effUp;
    logic [9:0] bx, by, px;

    step_timer #(
        .STEP_DELAY(STEP_DELAY)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .enable_i(state_q == ST_MOVE),
        .clear_i (state_q != ST_MOVE),
        .step_o  (step)
    );

    assign bx        = {1'b0, ballX_q};
    assign by        = {1'b0, ballY_q};
    assign px        = {1'b0, paddle_x};
    assign brickNow  = hitPending_q | brick_hit;
    assign paddleHit = (by + SIZE + SPD >= PAD_Y) && (by + SIZE <= PAD_Y) &&
                       (bx + SIZE >= px) && (bx <= px + PAD_W);
    // A brick reflection outside the wall/paddle cases moves the ball the new way at once.
    assign effUp     = (dy_q == DY_UP) != brickNow;

    always_comb begin
        state_d      = state_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        ballX_d      = ballX_q;
        ballY_d      = ballY_q;
        hitPending_d = hitPending_q;
        lives_d      = lives_q;

        if (brick_low && (state_q != ST_OVER)) begin
            state_d = ST_OVER;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ballX_d = 9'(px + HOLD_OFS);
                    ballY_d = REST_Y[8:0];
                    if (launch) begin
                        state_d      = ST_MOVE;
                        dx_d         = DX_RIGHT;
                        dy_d         = DY_UP;
                        hitPending_d = 1'b0;
                    end
                end
                ST_MOVE: begin
                    hitPending_d = step ? 1'b0 : brickNow;
                    if (step) begin
                        if ((dy_q == DY_DOWN) && (by + SIZE + SPD >= Y_LIMIT)) begin
                            state_d = ST_LOST;
                        end else begin
                            if (dx_q == DX_RIGHT) begin
                                if (bx + SPD >= X_MAX) begin
                                    ballX_d = X_MAX[8:0];
                                    dx_d    = DX_LEFT;
                                end else begin
                                    ballX_d = 9'(bx + SPD);
                                end
                            end else begin
                                if (bx <= SPD) begin
                                    ballX_d = '0;
                                    dx_d    = DX_RIGHT;
                                end else begin
                                    ballX_d = 9'(bx - SPD);
                                end
                            end

                            if ((dy_q == DY_DOWN) && paddleHit) begin
                                ballY_d = REST_Y[8:0];
                                dy_d    = brickNow ? DY_DOWN : DY_UP;
                            end else if ((dy_q == DY_UP) && (by <= SPD)) begin
                                ballY_d = '0;
                                dy_d    = brickNow ? DY_UP : DY_DOWN;
                            end else if (effUp) begin
                                ballY_d = (by <= SPD) ? '0 : 9'(by - SPD);
                                dy_d    = DY_UP;
                            end else begin
                                ballY_d = 9'(by + SPD);
                                dy_d    = DY_DOWN;
                            end
                        end
                    end
                end
                ST_LOST: begin
                    lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
                    state_d = (lives_q <= 3'd1) ? ST_OVER : ST_IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dx_q         <= DX_RIGHT;
            dy_q         <= DY_UP;
            ballX_q      <= START_X;
            ballY_q      <= REST_Y[8:0];
            hitPending_q <= 1'b0;
            lives_q      <= 3'(LIVES);
            active_q     <= 1'b0;
            lost_q       <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            ballX_q      <= ballX_d;
            ballY_q      <= ballY_d;
            hitPending_q <= hitPending_d;
            lives_q      <= lives_d;
            active_q     <= (state_d == ST_MOVE);
            lost_q       <= (state_d == ST_LOST);
            over_q       <= (state_d == ST_OVER);
        end
    end

    assign ball_x      = ballX_q;
    assign ball_y      = ballY_q;
    assign ball_active = active_q;
    assign ball_lost   = lost_q;
    assign lives       = lives_q;
    assign game_over   = over_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: directed vector table, hand-built corner sequences and random play,
// all compared each cycle against an arithmetic model of the ball game.
module tb_ball_ctrl;
    localparam int STEP     = 4;
    localparam int SPEED    = 1;
    localparam int FIELD_W  = 500;
    localparam int FIELD_H  = 480;
    localparam int BALL     = 20;
    localparam int PADDLE_W = 80;
    localparam int PADDLE_Y = 450;
    localparam int M_IDLE = 0, M_MOVE = 1, M_LOST = 2, M_OVER = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] paddle_x = '0;
    logic       launch = 1'b0, brick_hit = 1'b0, brick_low = 1'b0;
    logic [8:0] ball_x, ball_y;
    logic       ball_active, ball_lost, game_over;
    logic [2:0] lives;

    always #5 clk = ~clk;

    ball_ctrl #(
        .SPEED(SPEED),
        .STEP_DELAY(STEP),
        .LIVES(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .paddle_x   (paddle_x),
        .launch     (launch),
        .brick_hit  (brick_hit),
        .brick_low  (brick_low),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .ball_active(ball_active),
        .ball_lost  (ball_lost),
        .lives      (lives),
        .game_over  (game_over)
    );

    int checks = 0;
    int errors = 0;

    // Model of the game: velocities are signed unit steps, +y is downward.
    int mMode, mX, mY, mVx, mVy, mTick, mLives;
    bit mPend;

    typedef struct {
        int rst, px, la, bh, bl;
        int ex, ey, eact, elost, elives, eover;
    } vec_t;
    vec_t vecs[8];

    task automatic expectEq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name, input int budget);
        checks++;
        errors++;
        $display("[TB] FAIL %s: event not seen, required within %0d cycles", name, budget);
    endtask

    function automatic void modelReset();
        mMode  = M_IDLE;
        mX     = (FIELD_W - BALL) / 2;
        mY     = PADDLE_Y - BALL;
        mVx    = 1;
        mVy    = -1;
        mTick  = 0;
        mPend  = 0;
        mLives = 3;
    endfunction

    function automatic void modelClock(input bit r, input int px, input bit la, input bit bh, input bit bl);
        bit stepNow, refl;
        int ox;
        if (r) begin
            modelReset();
            return;
        end
        if (bl && mMode != M_OVER) begin
            mMode = M_OVER;
        end else begin
            case (mMode)
                M_IDLE: begin
                    mX = (px + PADDLE_W / 2 - BALL / 2) % 512;
                    mY = PADDLE_Y - BALL;
                    if (la) begin
                        mMode = M_MOVE;
                        mVx   = 1;
                        mVy   = -1;
                        mPend = 0;
                    end
                end
                M_MOVE: begin
                    stepNow = (mTick == STEP - 1);
                    mTick   = stepNow ? 0 : mTick + 1;
                    if (!stepNow) begin
                        mPend = mPend | bh;
                    end else begin
                        refl  = mPend | bh;
                        mPend = 0;
                        if (mVy > 0 && mY + BALL + SPEED >= FIELD_H) begin
                            mMode = M_LOST;
                        end else begin
                            ox = mX;
                            mX = mX + mVx * SPEED;
                            if (mX >= FIELD_W - BALL) begin
                                mX  = FIELD_W - BALL;
                                mVx = -1;
                            end else if (mX <= 0) begin
                                mX  = 0;
                                mVx = 1;
                            end
                            if (mVy > 0 && mY + BALL + SPEED >= PADDLE_Y && mY + BALL <= PADDLE_Y &&
                                ox + BALL >= px && ox <= px + PADDLE_W) begin
                                mY  = PADDLE_Y - BALL;
                                mVy = refl ? 1 : -1;
                            end else if (mVy < 0 && mY <= SPEED) begin
                                mY  = 0;
                                mVy = refl ? -1 : 1;
                            end else begin
                                if (refl) mVy = -mVy;
                                mY = mY + mVy * SPEED;
                                if (mY < 0) mY = 0;
                            end
                        end
                    end
                end
                M_LOST: begin
                    mMode = (mLives <= 1) ? M_OVER : M_IDLE;
                    if (mLives > 0) mLives--;
                end
                default: begin
                end
            endcase
        end
        if (mMode != M_MOVE) mTick = 0;
    endfunction

    task automatic applyStimulus(input bit r, input int px, input bit la, input bit bh, input bit bl);
        rst       = r;
        paddle_x  = 9'(px);
        launch    = la;
        brick_hit = bh;
        brick_low = bl;
        @(posedge clk);
        modelClock(r, px, la, bh, bl);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        expectEq({tag, ".ball_x"}, int'(ball_x), mX);
        expectEq({tag, ".ball_y"}, int'(ball_y), mY);
        expectEq({tag, ".ball_active"}, int'(ball_active), (mMode == M_MOVE) ? 1 : 0);
        expectEq({tag, ".ball_lost"}, int'(ball_lost), (mMode == M_LOST) ? 1 : 0);
        expectEq({tag, ".lives"}, int'(lives), mLives);
        expectEq({tag, ".game_over"}, int'(game_over), (mMode == M_OVER) ? 1 : 0);
    endtask

    task automatic cycle(input bit r, input int px, input bit la, input bit bh, input bit bl);
        applyStimulus(r, px, la, bh, bl);
        checkOutput("model");
    endtask

    function automatic int trackPx();
        return (mX >= 30) ? mX - 30 : 0;
    endfunction

    function automatic int farPx();
        return (mX >= 200) ? 0 : 400;
    endfunction

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int y0, fx, fy;
        modelReset();

        // Reset, paddle hold, launch and the first paced step.
        vecs[0] = '{1, 0,   0, 0, 0, 240, 430, 0, 0, 3, 0};
        vecs[1] = '{1, 0,   0, 0, 0, 240, 430, 0, 0, 3, 0};
        vecs[2] = '{0, 100, 0, 0, 0, 130, 430, 0, 0, 3, 0};
        vecs[3] = '{0, 100, 1, 0, 0, 130, 430, 1, 0, 3, 0};
        vecs[4] = '{0, 100, 0, 0, 0, 130, 430, 1, 0, 3, 0};
        vecs[5] = '{0, 100, 0, 0, 0, 130, 430, 1, 0, 3, 0};
        vecs[6] = '{0, 100, 0, 0, 0, 130, 430, 1, 0, 3, 0};
        vecs[7] = '{0, 100, 0, 0, 0, 131, 429, 1, 0, 3, 0};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].rst[0], vecs[i].px, vecs[i].la[0], vecs[i].bh[0], vecs[i].bl[0]);
            checkOutput("model");
            expectEq($sformatf("vec%0d.ball_x", i), int'(ball_x), vecs[i].ex);
            expectEq($sformatf("vec%0d.ball_y", i), int'(ball_y), vecs[i].ey);
            expectEq($sformatf("vec%0d.ball_active", i), int'(ball_active), vecs[i].eact);
            expectEq($sformatf("vec%0d.ball_lost", i), int'(ball_lost), vecs[i].elost);
            expectEq($sformatf("vec%0d.lives", i), int'(lives), vecs[i].elives);
            expectEq($sformatf("vec%0d.game_over", i), int'(game_over), vecs[i].eover);
        end

        repeat (36) cycle(0, 100, 0, 0, 0);
        expectEq("travel40.ball_x", int'(ball_x), 140);
        expectEq("travel40.ball_y", int'(ball_y), 420);

        // Right wall: clamp to 480, then come back.
        for (int i = 0; i < 3000 && mX != 480; i++) cycle(0, 100, 0, 0, 0);
        if (mX != 480) timeoutFail("rightWall", 3000);
        expectEq("rightWall.ball_x", int'(ball_x), 480);
        repeat (STEP) cycle(0, 100, 0, 0, 0);
        expectEq("rightWall.back", int'(ball_x), 479);

        // Brick hit two cycles before a step while moving up.
        for (int i = 0; i < 8 && mTick != 1; i++) cycle(0, 100, 0, 0, 0);
        y0 = mY;
        cycle(0, 100, 0, 1, 0);
        cycle(0, 100, 0, 0, 0);
        cycle(0, 100, 0, 0, 0);
        expectEq("brick.firstStep", int'(ball_y), y0 + 1);
        repeat (STEP) cycle(0, 100, 0, 0, 0);
        expectEq("brick.noReflectAgain", int'(ball_y), y0 + 2);

        // Paddle kept under the falling ball.
        for (int i = 0; i < 4000 && !(mY == 429 && mVy > 0); i++) cycle(0, trackPx(), 0, 0, 0);
        if (!(mY == 429 && mVy > 0)) timeoutFail("paddleApproach", 4000);
        repeat (STEP) cycle(0, trackPx(), 0, 0, 0);
        expectEq("paddle.bounceY", int'(ball_y), 430);
        repeat (STEP) cycle(0, trackPx(), 0, 0, 0);
        expectEq("paddle.goingUp", int'(ball_y), 429);

        // Three misses with the paddle held away from the ball.
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) cycle(0, farPx(), 1, 0, 0);
            for (int i = 0; i < 8000 && mMode != M_LOST; i++) cycle(0, farPx(), 0, 0, 0);
            if (mMode != M_LOST) timeoutFail("missWait", 8000);
            expectEq($sformatf("miss%0d.ball_lost", k), int'(ball_lost), 1);
            cycle(0, farPx(), 0, 0, 0);
            expectEq($sformatf("miss%0d.lives", k), int'(lives), 3 - k);
            expectEq($sformatf("miss%0d.ball_active", k), int'(ball_active), 0);
            expectEq($sformatf("miss%0d.ball_lost_cleared", k), int'(ball_lost), 0);
        end
        expectEq("over.game_over", int'(game_over), 1);
        fx = mX;
        fy = mY;
        for (int i = 0; i < 8; i++) cycle(0, $urandom_range(0, 420), 1, 1, 0);
        expectEq("over.frozenX", int'(ball_x), fx);
        expectEq("over.frozenY", int'(ball_y), fy);
        expectEq("over.lives", int'(lives), 0);

        // brick_low during flight ends the game without costing a life.
        cycle(1, 150, 0, 0, 0);
        cycle(1, 150, 0, 0, 0);
        expectEq("rst2.game_over", int'(game_over), 0);
        expectEq("rst2.lives", int'(lives), 3);
        cycle(0, 150, 1, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 150, 0, ($urandom_range(0, 3) == 0), 0);
        cycle(0, 150, 0, 0, 1);
        expectEq("low.game_over", int'(game_over), 1);
        expectEq("low.lives", int'(lives), 3);
        expectEq("low.ball_active", int'(ball_active), 0);
        repeat (4) cycle(0, 150, 1, 0, 0);

        // Random play against the model.
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 6000; i++) begin
            cycle(($urandom_range(0, 2999) == 0), $urandom_range(0, 420),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 4999) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
